mul_iterative: RTL and testbench



---
 rtl/mul_iterative_pkg.sv | 50 +++++
 rtl/mul_iterative_if.sv | 36 +++
 rtl/mul_iterative_chunk_mac.sv | 45 ++++
 rtl/mul_iterative.sv | 153 +++++++++++++++
 tb/tb_mul_iterative.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_iterative_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_iterative_pkg
// Description : Shared types for the iterative M-extension multiplier:
//               the execute-stage operation enum, the multiplier FSM
//               state enum and the signed_mode encodings.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mul_iterative_pkg;

  // Execute-stage operation subset seen by the multiplier. Non-multiply
  // entries exist so that a start with a foreign op can be rejected.
  typedef enum logic [3:0] {
    NOP    = 4'd0,
    ADD    = 4'd1,
    SUB    = 4'd2,
    DIV    = 4'd3,
    DIVU   = 4'd4,
    MUL    = 4'd5,
    MULH   = 4'd6,
    MULHSU = 4'd7,
    MULHU  = 4'd8
  } iType_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // bit0 treats rs1 as signed, bit1 treats rs2 as signed
  localparam logic [1:0] SIGNED_NONE = 2'b00;
  localparam logic [1:0] SIGNED_RS1  = 2'b01;
  localparam logic [1:0] SIGNED_BOTH = 2'b11;

  function automatic logic is_mul_op(iType_e op);
    return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == MULHU);
  endfunction

  function automatic logic [1:0] signed_mode_of(iType_e op);
    logic [1:0] mode;
    mode = SIGNED_NONE;
    if (op == MULH)   mode = SIGNED_BOTH;
    if (op == MULHSU) mode = SIGNED_RS1;
    return mode;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_iterative_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_iterative_if
// Description : Request/response bundle between the execute stage (master)
//               and the iterative multiplier (slave).
// Ports       : start_i, operation_i, first_operand_i, second_operand_i,
//               kill_i (master -> slave); ready_o, done_o, result_o
//               (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_iterative_if #(
  parameter int XLEN = 32
);
  import mul_iterative_pkg::*;

  logic            start_i;
  iType_e          operation_i;
  logic [XLEN-1:0] first_operand_i;
  logic [XLEN-1:0] second_operand_i;
  logic            kill_i;
  logic            ready_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, operation_i, first_operand_i, second_operand_i, kill_i,
    input  ready_o, done_o, result_o
  );

  modport slave (
    input  start_i, operation_i, first_operand_i, second_operand_i, kill_i,
    output ready_o, done_o, result_o
  );

endinterface
`default_nettype wire

// File: rtl/mul_iterative_chunk_mac.sv
`default_nettype none
// ============================================================================
// Module      : mul_chunk_mac
// Description : One multiply-accumulate step: a signed (CHUNK+1)x(CHUNK+1)
//               product of two extended chunks, sign-extended to 2*XLEN,
//               shifted to chunk position pos (= i+j) and added to acc_in.
// Ports       : a_chunk/b_chunk (chunk bits), a_ext/b_ext (extension bit),
//               pos (chunk position), acc_in (accumulator), acc_out (sum)
// Revision    : 1.0 - initial release
// ============================================================================
module mul_chunk_mac #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 16,
  parameter int PW    = 2
) (
  input  logic [CHUNK-1:0]  a_chunk,
  input  logic [CHUNK-1:0]  b_chunk,
  input  logic              a_ext,
  input  logic              b_ext,
  input  logic [PW-1:0]     pos,
  input  logic [2*XLEN-1:0] acc_in,
  output logic [2*XLEN-1:0] acc_out
);

  localparam int PPW = 2 * CHUNK + 2;
  localparam int AW  = 2 * XLEN;
  localparam int SHW = $clog2(AW) + 1;

  logic signed [CHUNK:0]  a_s;
  logic signed [CHUNK:0]  b_s;
  logic signed [PPW-1:0]  prod;
  logic [AW-1:0]          prod_ext;
  logic [SHW-1:0]         shamt;

  assign a_s      = {a_ext, a_chunk};
  assign b_s      = {b_ext, b_chunk};
  assign prod     = PPW'(a_s) * PPW'(b_s);
  // The size cast sign-extends; when CHUNK == XLEN it truncates the two
  // surplus bits, which is harmless because the accumulator is mod 2^AW.
  assign prod_ext = AW'(prod);
  assign shamt    = SHW'(pos) * SHW'(CHUNK);
  assign acc_out  = acc_in + (prod_ext << shamt);

endmodule
`default_nettype wire

// File: rtl/mul_iterative.sv
`default_nettype none
// ============================================================================
// Module      : mul_iterative
// Description : Multi-cycle RV M-extension multiplier (MUL/MULH/MULHSU/
//               MULHU). One CHUNK x CHUNK signed partial product is
//               accumulated per cycle; zero operands finish immediately.
// Ports       : clk, reset (sync, active-high),
//               bus (mul_iterative_if.slave): start_i, operation_i,
//               first_operand_i, second_operand_i, kill_i, ready_o,
//               done_o, result_o
// Revision    : 1.0 - initial release
// ============================================================================
module mul_iterative
  import mul_iterative_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CHUNK = 16
) (
  input  logic           clk,
  input  logic           reset,
  mul_iterative_if.slave bus
);

  localparam int N  = XLEN / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = CW + 1;

  mul_state_e         state;
  logic [XLEN-1:0]    op_a;
  logic [XLEN-1:0]    op_b;
  logic               low_half;      // MUL: keep the lower result half
  logic [1:0]         signed_mode;
  logic [CW-1:0]      i_cnt;
  logic [CW-1:0]      j_cnt;
  logic [2*XLEN-1:0]  acc;
  logic [2*XLEN-1:0]  acc_next;
  logic [XLEN-1:0]    result;
  logic               ready;
  logic               done;

  logic [N-1:0][CHUNK-1:0] a_chunks;
  logic [N-1:0][CHUNK-1:0] b_chunks;
  logic [CHUNK-1:0]        a_chunk;
  logic [CHUNK-1:0]        b_chunk;
  logic                    a_ext;
  logic                    b_ext;
  logic [PW-1:0]           pos;
  logic                    i_last;
  logic                    last_pair;
  logic                    accept;
  logic                    zero_operand;

  assign a_chunks = op_a;
  assign b_chunks = op_b;
  assign a_chunk  = a_chunks[i_cnt];
  assign b_chunk  = b_chunks[j_cnt];

  // Only the top chunk of a signed operand carries its sign.
  assign a_ext = signed_mode[0] & (i_cnt == CW'(N - 1)) & a_chunk[CHUNK-1];
  assign b_ext = signed_mode[1] & (j_cnt == CW'(N - 1)) & b_chunk[CHUNK-1];

  assign pos = PW'(i_cnt) + PW'(j_cnt);

  // MUL only needs pairs landing below XLEN, so its inner loop ends at
  // i+j = N-1; the high ops sweep the full N x N square.
  assign i_last    = low_half ? (pos == PW'(N - 1)) : (i_cnt == CW'(N - 1));
  assign last_pair = i_last & (j_cnt == CW'(N - 1));

  assign accept       = ready & bus.start_i & is_mul_op(bus.operation_i) & ~bus.kill_i;
  assign zero_operand = (bus.first_operand_i == '0) | (bus.second_operand_i == '0);

  mul_chunk_mac #(
    .XLEN  (XLEN),
    .CHUNK (CHUNK),
    .PW    (PW)
  ) u_mac (
    .a_chunk (a_chunk),
    .b_chunk (b_chunk),
    .a_ext   (a_ext),
    .b_ext   (b_ext),
    .pos     (pos),
    .acc_in  (acc),
    .acc_out (acc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      low_half    <= 1'b0;
      signed_mode <= SIGNED_NONE;
      i_cnt       <= '0;
      j_cnt       <= '0;
      acc         <= '0;
      result      <= '0;
      done        <= 1'b0;
      ready       <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        MAC: begin
          if (bus.kill_i) begin
            // Abandon the operation; result keeps the last committed value.
            state <= IDLE;
            ready <= 1'b1;
          end else begin
            acc <= acc_next;
            if (last_pair) begin
              state  <= DONE;
              ready  <= 1'b1;
              done   <= 1'b1;
              result <= low_half ? acc_next[XLEN-1:0] : acc_next[2*XLEN-1:XLEN];
            end else if (i_last) begin
              i_cnt <= '0;
              j_cnt <= j_cnt + CW'(1);
            end else begin
              i_cnt <= i_cnt + CW'(1);
            end
          end
        end
        default: begin
          // IDLE and DONE behave alike: both may accept a new request.
          if (accept) begin
            op_a        <= bus.first_operand_i;
            op_b        <= bus.second_operand_i;
            low_half    <= (bus.operation_i == MUL);
            signed_mode <= signed_mode_of(bus.operation_i);
            acc         <= '0;
            i_cnt       <= '0;
            j_cnt       <= '0;
            if (zero_operand) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= '0;
            end else begin
              state <= MAC;
              ready <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.ready_o  = ready;
  assign bus.done_o   = done;
  assign bus.result_o = result;

endmodule
`default_nettype wire

// File: tb/tb_mul_iterative.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_iterative
// Description : Self-checking bench for mul_iterative. A 32/16 instance is
//               compared every cycle against a countdown/arithmetic model;
//               64/16 and 32/32 instances get directed latency/result checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_iterative;
  import mul_iterative_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic chk_en;

  mul_iterative_if #(.XLEN(32)) b32 ();
  mul_iterative_if #(.XLEN(64)) b64 ();
  mul_iterative_if #(.XLEN(32)) b1c ();

  mul_iterative #(.XLEN(32), .CHUNK(16)) dut32 (.clk(clk), .reset(reset), .bus(b32));
  mul_iterative #(.XLEN(64), .CHUNK(16)) dut64 (.clk(clk), .reset(reset), .bus(b64));
  mul_iterative #(.XLEN(32), .CHUNK(32)) dut1c (.clk(clk), .reset(reset), .bus(b1c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Full-precision reference: extend operands per op, multiply, pick a half.
  function automatic logic [63:0] ref_result(iType_e op, int xlen, logic [63:0] a, logic [63:0] b);
    logic [129:0]        mask;
    logic signed [129:0] sa;
    logic signed [129:0] sb;
    logic signed [129:0] p;
    logic [129:0]        hi;
    mask = (130'd1 << xlen) - 130'd1;
    sa = {66'd0, a & mask[63:0]};
    sb = {66'd0, b & mask[63:0]};
    if ((op == MULH || op == MULHSU) && a[xlen-1]) sa = sa | ~mask;
    if (op == MULH && b[xlen-1]) sb = sb | ~mask;
    p  = sa * sb;
    hi = p >> xlen;
    if (op == MUL) return p[63:0] & mask[63:0];
    return hi[63:0] & mask[63:0];
  endfunction

  function automatic logic [31:0] m32(iType_e op, logic [31:0] a, logic [31:0] b);
    logic [63:0] r;
    r = ref_result(op, 32, {32'd0, a}, {32'd0, b});
    return r[31:0];
  endfunction

  function automatic int mac_cycles(iType_e op, int n);
    return (op == MUL) ? n * (n + 1) / 2 : n * n;
  endfunction

  // ---------------- behavioural model of the 32/16 instance ----------------
  int          m_rem;      // MAC cycles still to go; 0 means ready
  logic        m_done;
  logic [31:0] m_result;
  logic [31:0] m_pending;

  always @(posedge clk) begin
    if (reset) begin
      m_rem    <= 0;
      m_done   <= 1'b0;
      m_result <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        if (b32.kill_i) m_rem <= 0;
        else begin
          m_rem <= m_rem - 1;
          if (m_rem == 1) begin
            m_done   <= 1'b1;
            m_result <= m_pending;
          end
        end
      end else if (b32.start_i && !b32.kill_i &&
                   (b32.operation_i inside {MUL, MULH, MULHSU, MULHU})) begin
        if (b32.first_operand_i == 0 || b32.second_operand_i == 0) begin
          m_done   <= 1'b1;
          m_result <= '0;
        end else begin
          m_rem     <= mac_cycles(b32.operation_i, 2);
          m_pending <= m32(b32.operation_i, b32.first_operand_i, b32.second_operand_i);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc ready", {63'd0, b32.ready_o}, {63'd0, (m_rem == 0)});
      check("cyc done", {63'd0, b32.done_o}, {63'd0, m_done});
      check("cyc result", {32'd0, b32.result_o}, {32'd0, m_result});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(int d, logic st, iType_e op, logic [63:0] a, logic [63:0] b);
    case (d)
      0: begin b32.start_i = st; b32.operation_i = op; b32.first_operand_i = a[31:0]; b32.second_operand_i = b[31:0]; end
      1: begin b64.start_i = st; b64.operation_i = op; b64.first_operand_i = a;       b64.second_operand_i = b;       end
      default: begin b1c.start_i = st; b1c.operation_i = op; b1c.first_operand_i = a[31:0]; b1c.second_operand_i = b[31:0]; end
    endcase
  endtask

  function automatic logic done_of(int d);
    case (d)
      0: return b32.done_o;
      1: return b64.done_o;
      default: return b1c.done_o;
    endcase
  endfunction

  function automatic logic [63:0] result_of(int d);
    case (d)
      0: return {32'd0, b32.result_o};
      1: return b64.result_o;
      default: return {32'd0, b1c.result_o};
    endcase
  endfunction

  // Issue one request (caller is at posedge+1 with the DUT ready), scramble
  // the operands after accept and measure cycles until done_o.
  task automatic run_op(int d, string nm, iType_e op, logic [63:0] a, logic [63:0] b,
                        logic [63:0] exp_res, int exp_lat);
    int cyc;
    drive(d, 1'b1, op, a, b);
    @(posedge clk); #1;
    drive(d, 1'b0, NOP, {$urandom, $urandom}, {$urandom, $urandom});
    cyc = 1;
    while (!done_of(d) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({nm, " latency"}, 64'(cyc), 64'(exp_lat));
    check({nm, " result"}, result_of(d), exp_res);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    reset  = 1'b1;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, NOP, 64'd0, 64'd0);
    b32.kill_i = 1'b0;
    b64.kill_i = 1'b0;
    b1c.kill_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    check("reset ready", {63'd0, b32.ready_o}, 64'd1);
    check("reset done", {63'd0, b32.done_o}, 64'd0);
    check("reset result", {32'd0, b32.result_o}, 64'd0);

    // Pin the reference model with hand-computed products.
    check("model mul", {32'd0, m32(MUL, 32'h1234, 32'h5678)}, 64'h0626_0060);
    check("model mulh", {32'd0, m32(MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF)}, 64'h0);
    check("model mulhu", {32'd0, m32(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF)}, 64'hFFFF_FFFE);
    check("model mulhsu", {32'd0, m32(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF)}, 64'hFFFF_FFFF);
    check("model mul neg", {32'd0, m32(MUL, 32'd3, 32'hFFFF_FFFB)}, 64'hFFFF_FFF1);
    check("model 64 mulhu", ref_result(MULHU, 64, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2), 64'd1);

    // Directed 32/16 sequences; later ones start in the DONE cycle.
    run_op(0, "mul 1234x5678", MUL, 64'h1234, 64'h5678, 64'h0626_0060, 4);
    run_op(0, "mulh ff", MULH, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h0, 5);
    run_op(0, "mulhu ff", MULHU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 5);
    run_op(0, "mulhsu ff", MULHSU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5);
    run_op(0, "mulh min", MULH, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 5);
    run_op(0, "mul b2b 3x-5", MUL, 64'd3, 64'hFFFF_FFFB, 64'hFFFF_FFF1, 4);
    @(posedge clk); #1;
    run_op(0, "mul zero", MUL, 64'd0, 64'hDEAD_BEEF, 64'd0, 1);

    // start held while busy must be ignored
    @(posedge clk); #1;
    drive(0, 1'b1, MULHU, 64'h0001_0000, 64'h0003_0000);
    @(posedge clk); #1;
    drive(0, 1'b1, MUL, 64'd5, 64'd7);
    repeat (3) begin @(posedge clk); #1; end
    drive(0, 1'b0, NOP, 64'd0, 64'd0);
    @(posedge clk); #1;
    check("busy start done", {63'd0, b32.done_o}, 64'd1);
    check("busy start result", {32'd0, b32.result_o}, 64'd3);
    @(posedge clk); #1;
    check("busy start no extra done", {63'd0, b32.done_o}, 64'd0);

    // non-multiply op ignored in IDLE
    drive(0, 1'b1, DIV, 64'd9, 64'd3);
    @(posedge clk); #1;
    drive(0, 1'b0, NOP, 64'd0, 64'd0);
    check("nonmul ready", {63'd0, b32.ready_o}, 64'd1);

    // kill mid-MAC keeps the previous result
    run_op(0, "mul 1234x1", MUL, 64'h1234, 64'd1, 64'h1234, 4);
    drive(0, 1'b1, MULHU, 64'hFFFF_0000, 64'h0001_2345);
    @(posedge clk); #1;
    drive(0, 1'b0, NOP, 64'd0, 64'd0);
    @(posedge clk); #1;
    b32.kill_i = 1'b1;
    @(posedge clk); #1;
    b32.kill_i = 1'b0;
    check("kill ready", {63'd0, b32.ready_o}, 64'd1);
    check("kill result", {32'd0, b32.result_o}, 64'h1234);
    repeat (4) begin @(posedge clk); #1; end

    // kill beats a start issued in the DONE cycle
    run_op(0, "mul 2x3", MUL, 64'd2, 64'd3, 64'd6, 4);
    drive(0, 1'b1, MULH, 64'd11, 64'd13);
    b32.kill_i = 1'b1;
    @(posedge clk); #1;
    b32.kill_i = 1'b0;
    drive(0, 1'b0, NOP, 64'd0, 64'd0);
    check("kill start ready", {63'd0, b32.ready_o}, 64'd1);

    // reset mid-MAC
    drive(0, 1'b1, MULH, 64'h1357_9BDF, 64'h2468_ACE0);
    @(posedge clk); #1;
    drive(0, 1'b0, NOP, 64'd0, 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid reset ready", {63'd0, b32.ready_o}, 64'd1);
    check("mid reset result", {32'd0, b32.result_o}, 64'd0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(0, ($urandom_range(0, 2) == 0), iType_e'($urandom_range(0, 8)),
            {32'd0, rnd_operand()}, {32'd0, rnd_operand()});
      b32.kill_i = ($urandom_range(0, 15) == 0);
      reset      = ($urandom_range(0, 63) == 0);
      @(posedge clk); #1;
    end
    drive(0, 1'b0, NOP, 64'd0, 64'd0);
    b32.kill_i = 1'b0;
    reset      = 1'b0;

    // wider and narrower configurations
    run_op(1, "64 mulhu", MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 17);
    run_op(1, "64 mul", MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 11);
    run_op(1, "64 mulhsu", MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 17);
    run_op(1, "64 mulh", MULH, 64'h8000_0000_0000_0000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 17);
    run_op(2, "c32 mul", MUL, 64'd7, 64'd6, 64'd42, 2);
    run_op(2, "c32 mulh", MULH, 64'hFFFF_FFFD, 64'd5, 64'hFFFF_FFFF, 2);
    run_op(2, "c32 mulhu", MULHU, 64'hFFFF_FFFD, 64'd5, 64'd4, 2);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
